aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Sequential AES-128 key schedule (FIPS-197 5.2, Nk=4, Nr=10). It sits directly upstream of aes_core.
//  On start it latches the 128-bit key and streams round keys 0..NR, one per valid/ready handshake.
//  The cipher datapath consumes each round key in its AddRoundKey step.
//  Words are packed as w[0]=[127:96] .. w[3]=[31:0], matching the aes_core state packing.
// PARAMETERS
//  NR         10      number of rounds; round keys 0..NR are emitted (NR+1 keys)
//  RCON_INIT  8'h01   Rcon byte used to generate round key 1
// PORTS
//  clk        in   1    single clock, all state on posedge
//  reset      in   1    asynchronous, active-high; clears all state
//  start      in   1    1-cycle pulse; samples key, (re)starts the schedule
//  key        in   128  cipher key, sampled only when start=1
//  rk_valid   out  1    round_key/rk_idx are valid
//  rk_ready   in   1    consumer accepts the current round key
//  round_key  out  128  current round key {w0,w1,w2,w3}
//  rk_idx     out  4    index of round_key, 0..NR
//  busy       out  1    schedule in progress (state != IDLE)
//  done       out  1    1-cycle pulse on the cycle after round key NR is accepted
// BEHAVIOUR
//  - Reset values: rk_valid=0, round_key=0, rk_idx=0, busy=0, done=0. Internal rcon=RCON_INIT, state=IDLE.
//  - States: IDLE, EMIT, SUB.
//    IDLE: outputs idle. start -> round_key<=key, rk_idx<=0, rcon<=RCON_INIT, go to EMIT.
//    EMIT: rk_valid=1. round_key/rk_idx are held stable while rk_ready=0 (no drop, no change).
//      On handshake with rk_idx<NR -> SUB. On handshake with rk_idx==NR -> IDLE and pulse done.
//    SUB: the registered SubWord is valid. Register the next key: rk_idx++, rcon<=xtime(rcon), go to EMIT.
//  - Next key:
//      t  = SubWord(RotWord(w3)) ^ {rcon,24'h0}
//      w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
//  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
//  - SubWord uses 4 synchronous sbox ROMs (1-cycle latency). Their address is driven continuously from
//    RotWord(round_key.w3). The key register only changes on the SUB->EMIT edge, so the sbox output
//    seen in SUB always matches the current key.
//  - Latency: start edge -> rk_valid on the next cycle (key 0 costs no sbox).
//    Each handshake -> next rk_valid 2 cycles later (one dead SUB cycle).
//    With ready tied high, the full schedule takes 1+2*NR cycles from start to the final acceptance.
//  - rcon update uses xtime via galoismult: 01,02,04,08,10,20,40,80,1b,36 (wraps through 0x1b, no overflow).
//  - rk_idx is 4 bits; NR must be <=15. Indices never wrap within one schedule.
//  - start while busy (EMIT or SUB) wins over everything else: the new key is reloaded, rk_idx=0, go to EMIT.
//    If start coincides with the final handshake, done is suppressed.
//  - A handshake does not exist when rk_valid=0; rk_ready is ignored in IDLE and SUB.
//  - reset asserted mid-schedule: everything returns immediately to reset values; no done pulse.
//  - done is combinationally independent of rk_ready; it is registered.
// STRUCTURE
//  - aes_pkg (shared): typedef enum logic [1:0] {IDLE,EMIT,SUB} ks_state_t;
//    localparam AES_NR=10; RCON_INIT=8'h01; typedef logic [3:0][31:0] aes_block_t.
//  - Sub-module aes_subword: 4x sbox_sync instances mapping a 32-bit word to its substituted word,
//    registered, 1-cycle latency.
//  - Reuses galoismult for the rcon update. No other hierarchy.
// TESTING
//  1. FIPS-197 A.1 key, rk_ready=1, start:
//     key=2b7e151628aed2a6abf7158809cf4f3c
//     rk_idx=1 -> a0fafe1788542cb123a339392a6c7605
//     rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
//     Expect 11 keys total and a single done pulse.
//  2. key=0, start -> rk_idx=1 round_key = 62636363626363636263636362636363.
//     Check that the rcon progression ends at 36 for rk_idx=10.
//  3. Backpressure: rk_ready=0 for 5 cycles at rk_idx=3 -> round_key and rk_idx stay stable and rk_valid stays 1.
//     Release -> rk_idx=4 follows 2 cycles later.
//  4. Restart: start with key A, then at rk_idx=5 start with the A.1 key -> next output is rk_idx=0 equal to the
//     new key. No done pulse for the aborted run.
//  5. Reset mid-schedule at rk_idx=7 -> next cycle all outputs are 0 and busy=0.
//     A following start runs a full correct schedule.
//  6. start coincident with the final handshake (rk_idx=10) -> no done pulse.
//     rk_idx=0 is valid on the next cycle with the new key.

Source files
------------

// File: rtl/aes_key_expand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_pkg
// Brief    : Shared types, constants and GF(2^8) helpers for the AES key schedule
// Revision : 1.0 - initial release
// ============================================================================
package aes_key_expand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2
    } ks_state_t;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    // Index 3 is w0 ([127:96]) and index 0 is w3 ([31:0]).
    typedef logic [3:0][31:0] aes_block_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h01;
        pw  = a;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_if
// Brief    : Start/key and round-key streaming handshake of the key schedule
// Revision : 1.0 - initial release
// ============================================================================
interface aes_key_expand_if;

    logic         start;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    modport master (
        output start, key, rk_ready,
        input  rk_valid, round_key, rk_idx, busy, done
    );

    modport slave (
        input  start, key, rk_ready,
        output rk_valid, round_key, rk_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/aes_key_expand_subword.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_subword
// Brief    : SubWord over four synchronous S-boxes, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand_subword (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] word_i,
    output logic      [31:0] word_o
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox_sync u_sbox (
            .clk    (clk),
            .rst    (rst),
            .addr_i (word_i[8*g +: 8]),
            .data_o (word_o[8*g +: 8])
        );
    end

endmodule
`default_nettype wire

// File: rtl/galoismult.sv
`default_nettype none
// ============================================================================
// Module   : galoismult
// Brief    : Combinational GF(2^8) multiplier, AES polynomial x^8+x^4+x^3+x+1
// Revision : 1.0 - initial release
// ============================================================================
module galoismult
    import aes_key_expand_pkg::*;
(
    input  wire logic [7:0] a_i,
    input  wire logic [7:0] b_i,
    output logic      [7:0] p_o
);

    always_comb begin
        p_o = gf_mul(a_i, b_i);
    end

endmodule
`default_nettype wire

// File: rtl/sbox_sync.sv
`default_nettype none
// ============================================================================
// Module   : sbox_sync
// Brief    : AES forward S-box with registered output (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module sbox_sync
    import aes_key_expand_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] addr_i,
    output logic      [7:0] data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= sbox(addr_i);
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand
// Brief    : Sequential AES-128 key schedule streaming round keys 0..NR
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    aes_key_expand_if.slave   ks_if
);

    ks_state_t  state_q, state_d;
    aes_block_t round_key_q, round_key_d;
    logic [3:0] rk_idx_q, rk_idx_d;
    logic [7:0] rcon_q, rcon_d;
    logic       done_q, done_d;

    logic [31:0] rot_w3;
    logic [31:0] sub_w;
    logic [31:0] t_word;
    logic [7:0]  rcon_next;
    aes_block_t  next_key;

    // The S-box address follows the key register continuously, so in SUB
    // the registered SubWord always belongs to the key currently held.
    assign rot_w3 = {round_key_q[0][23:0], round_key_q[0][31:24]};

    aes_key_expand_subword u_subword (
        .clk    (clk),
        .rst    (reset),
        .word_i (rot_w3),
        .word_o (sub_w)
    );

    galoismult u_rcon_xtime (
        .a_i (rcon_q),
        .b_i (8'h02),
        .p_o (rcon_next)
    );

    always_comb begin
        t_word      = sub_w ^ {rcon_q, 24'h0};
        next_key[3] = round_key_q[3] ^ t_word;
        next_key[2] = round_key_q[2] ^ next_key[3];
        next_key[1] = round_key_q[1] ^ next_key[2];
        next_key[0] = round_key_q[0] ^ next_key[1];
    end

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        rk_idx_d    = rk_idx_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;

        // A start pulse overrides any handshake, including the final one.
        if (ks_if.start) begin
            round_key_d = ks_if.key;
            rk_idx_d    = 4'd0;
            rcon_d      = RCON_INIT;
            state_d     = EMIT;
        end else begin
            case (state_q)
                EMIT: begin
                    if (ks_if.rk_ready) begin
                        if (rk_idx_q == 4'(NR)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SUB;
                        end
                    end
                end
                SUB: begin
                    round_key_d = next_key;
                    rk_idx_d    = rk_idx_q + 4'd1;
                    rcon_d      = rcon_next;
                    state_d     = EMIT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            rk_idx_q    <= '0;
            rcon_q      <= RCON_INIT;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rk_idx_q    <= rk_idx_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    assign ks_if.rk_valid  = (state_q == EMIT);
    assign ks_if.round_key = round_key_q;
    assign ks_if.rk_idx    = rk_idx_q;
    assign ks_if.busy      = (state_q != IDLE);
    assign ks_if.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand
// Brief    : Directed self-checking bench for the AES-128 key schedule
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_key_expand_if ks_if ();

    aes_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .ks_if (ks_if)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [127:0] a1 [0:10];
    localparam logic [127:0] C_Z1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] C_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] C_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1R = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    always @(negedge clk) if (ks_if.done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [159:0] pk(input logic b, input logic d, input logic v,
                                        input logic [3:0] idx, input logic [127:0] k);
        return {25'b0, b, d, v, idx, k};
    endfunction

    function automatic logic [159:0] obs();
        return pk(ks_if.busy, ks_if.done, ks_if.rk_valid, ks_if.rk_idx, ks_if.round_key);
    endfunction

    task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic pulse_start(input logic [127:0] k);
        ks_if.key   = k;
        ks_if.start = 1'b1;
        @(posedge clk); #1;
        ks_if.start = 1'b0;
        ks_if.key   = ~k;
    endtask

    task automatic advance_to(input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ks_if.rk_valid === 1'b1 && ks_if.rk_idx === 4'(target)) begin
                hit = 1'b1;
                break;
            end
            ks_if.rk_ready = 1'b1;
            @(posedge clk); #1;
        end
        ks_if.rk_ready = 1'b0;
        chk(tag, 160'(hit), 160'(1));
    endtask

    task automatic run_full_a1(input string tag);
        int d0;
        d0 = done_cnt;
        ks_if.rk_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            chk($sformatf("%s_key%0d", tag, k), obs(), pk(1'b1, 1'b0, 1'b1, 4'(k), a1[k]));
            @(posedge clk); #1;
            if (k < 10) begin
                chk($sformatf("%s_gap%0d", tag, k), obs(), pk(1'b1, 1'b0, 1'b0, 4'(k), a1[k]));
                @(posedge clk); #1;
            end
        end
        chk({tag, "_done"}, 160'({ks_if.busy, ks_if.done, ks_if.rk_valid}), 160'(3'b010));
        ks_if.rk_ready = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 160'({ks_if.busy, ks_if.done}), 160'(2'b00));
        chk({tag, "_done_count"}, 160'(done_cnt - d0), 160'(1));
    endtask

    initial begin
        int d0;
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset          = 1'b1;
        ks_if.start    = 1'b0;
        ks_if.key      = '0;
        ks_if.rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", obs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 128'h0));
        reset          = 1'b0;
        ks_if.rk_ready = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", obs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 128'h0));

        // FIPS-197 A.1 schedule at full rate
        pulse_start(a1[0]);
        run_full_a1("t1");

        // All-zero key
        d0 = done_cnt;
        pulse_start(128'h0);
        advance_to(1, "t2_reach1");
        chk("t2_key1", obs(), pk(1'b1, 1'b0, 1'b1, 4'd1, C_Z1));
        advance_to(10, "t2_reach10");
        chk("t2_key10", obs(), pk(1'b1, 1'b0, 1'b1, 4'd10, C_Z10));
        ks_if.rk_ready = 1'b1;
        @(posedge clk); #1;
        ks_if.rk_ready = 1'b0;
        chk("t2_done", 160'(ks_if.done), 160'(1));
        @(posedge clk); #1;
        chk("t2_done_count", 160'(done_cnt - d0), 160'(1));

        // Backpressure at rk_idx=3
        pulse_start(a1[0]);
        advance_to(3, "t3_reach3");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t3_hold%0d", c), obs(), pk(1'b1, 1'b0, 1'b1, 4'd3, a1[3]));
        end
        ks_if.rk_ready = 1'b1;
        @(posedge clk); #1;
        ks_if.rk_ready = 1'b0;
        chk("t3_gap", obs(), pk(1'b1, 1'b0, 1'b0, 4'd3, a1[3]));
        @(posedge clk); #1;
        chk("t3_key4", obs(), pk(1'b1, 1'b0, 1'b1, 4'd4, a1[4]));
        advance_to(10, "t3_reach10");
        ks_if.rk_ready = 1'b1;
        @(posedge clk); #1;
        ks_if.rk_ready = 1'b0;
        @(posedge clk); #1;

        // Restart mid-schedule, start coinciding with a handshake at rk_idx=5
        d0 = done_cnt;
        pulse_start(128'h0);
        advance_to(5, "t4_reach5");
        ks_if.rk_ready = 1'b1;
        pulse_start(a1[0]);
        ks_if.rk_ready = 1'b0;
        chk("t4_restart_key0", obs(), pk(1'b1, 1'b0, 1'b1, 4'd0, a1[0]));
        run_full_a1("t4");
        chk("t4_no_abort_done", 160'(done_cnt - d0), 160'(1));

        // Asynchronous reset at rk_idx=7
        pulse_start(128'h0);
        advance_to(7, "t5_reach7");
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("t5_reset_async", obs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 128'h0));
        @(posedge clk); #1;
        chk("t5_reset_held", obs(), pk(1'b0, 1'b0, 1'b0, 4'd0, 128'h0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_no_done", 160'(done_cnt - d0), 160'(0));
        pulse_start(a1[0]);
        run_full_a1("t5");

        // Start coinciding with the final handshake
        pulse_start(a1[0]);
        advance_to(10, "t6_reach10");
        d0 = done_cnt;
        ks_if.rk_ready = 1'b1;
        pulse_start(C_C1);
        ks_if.rk_ready = 1'b0;
        chk("t6_new_key0", obs(), pk(1'b1, 1'b0, 1'b1, 4'd0, C_C1));
        @(posedge clk); #1;
        chk("t6_no_done", 160'(done_cnt - d0), 160'(0));
        advance_to(1, "t6_reach1");
        chk("t6_new_key1", obs(), pk(1'b1, 1'b0, 1'b1, 4'd1, C_C1R));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
